// File: rtl/secuenciador_bloques_datos.sv
// -----------------------------------------------------------------------------
// secuenciador_bloques_datos
//
// Control-path sequencer for the data-block enable decoder. A start request
// walks the block-select code through the initialisation phase and then the
// enabled data phases (minutes/seconds, date, time). Each phase is held for
// T_FASE clock cycles. A one-cycle done pulse closes every sequence, whether
// it completes normally or is aborted.
//
// Parameters:
//   T_FASE      cycles each non-idle phase is held (1..255)
//   ANCHO_CONT  width of the phase-hold counter (2**ANCHO_CONT > T_FASE)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   inicio        start request, honoured only while idle
//   cancelar      abort request, honoured in any running phase
//   sel_bloques   phase mask latched at start: [0]=MS, [1]=fecha, [2]=hora
//   Selec_Mux_DD  registered block-select code to the enable decoder
//   ocupado       high while a sequence is running
//   fin           one-cycle pulse when a sequence completes or is aborted
//   fase_actual   encoded FSM state (debug)
// -----------------------------------------------------------------------------
module secuenciador_bloques_datos #(
  parameter int unsigned T_FASE     = 16,
  parameter int unsigned ANCHO_CONT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       cancelar,
  input  logic [2:0] sel_bloques,
  output logic [3:0] Selec_Mux_DD,
  output logic       ocupado,
  output logic       fin,
  output logic [2:0] fase_actual
);

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    INICIO = 3'd1,
    MS     = 3'd2,
    FECHA  = 3'd3,
    HORA   = 3'd4,
    FIN    = 3'd5
  } estado_t;

  localparam logic [ANCHO_CONT-1:0] CUENTA_MAX = ANCHO_CONT'(T_FASE - 1);

  estado_t               estado_q, estado_d;
  logic [ANCHO_CONT-1:0] cont_q, cont_d;
  logic [2:0]            mascara_q, mascara_d;
  logic [3:0]            sel_q, sel_d;
  logic                  ocupado_q, ocupado_d;
  logic                  fin_q, fin_d;

  // Next phase after the one that just ended, skipping disabled phases so the
  // following enabled code appears with no gap.
  function automatic estado_t siguiente_fase(input estado_t actual,
                                             input logic [2:0] mascara);
    estado_t sig;
    sig = FIN;
    case (actual)
      INICIO: begin
        if      (mascara[0]) sig = MS;
        else if (mascara[1]) sig = FECHA;
        else if (mascara[2]) sig = HORA;
      end
      MS: begin
        if      (mascara[1]) sig = FECHA;
        else if (mascara[2]) sig = HORA;
      end
      FECHA: begin
        if (mascara[2]) sig = HORA;
      end
      default: sig = FIN;
    endcase
    return sig;
  endfunction

  function automatic logic [3:0] codigo(input estado_t e);
    logic [3:0] c;
    case (e)
      INICIO:  c = 4'h1;
      MS:      c = 4'h2;
      FECHA:   c = 4'h3;
      HORA:    c = 4'h4;
      default: c = 4'h0;
    endcase
    return c;
  endfunction

  // NOTE: every variable gets its default before the case statement, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    estado_d  = estado_q;
    cont_d    = cont_q;
    mascara_d = mascara_q;

    case (estado_q)
      REPOSO: begin
        cont_d = '0;
        if (inicio) begin
          mascara_d = sel_bloques;
          estado_d  = INICIO;
        end
      end
      INICIO, MS, FECHA, HORA: begin
        if (cancelar) begin
          // Abort wins over a phase advance falling on the same cycle.
          cont_d   = '0;
          estado_d = FIN;
        end else if (cont_q == CUENTA_MAX) begin
          cont_d   = '0;
          estado_d = siguiente_fase(estado_q, mascara_q);
        end else begin
          cont_d = cont_q + ANCHO_CONT'(1);
        end
      end
      FIN: begin
        cont_d   = '0;
        estado_d = REPOSO;
      end
      default: begin
        cont_d   = '0;
        estado_d = REPOSO;
      end
    endcase

    // Outputs are decoded from the next state and registered alongside it, so
    // they change exactly with the state and never glitch.
    sel_d     = codigo(estado_d);
    ocupado_d = estado_d inside {INICIO, MS, FECHA, HORA};
    fin_d     = (estado_d == FIN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= REPOSO;
      cont_q    <= '0;
      mascara_q <= 3'b000;
      sel_q     <= 4'h0;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      mascara_q <= mascara_d;
      sel_q     <= sel_d;
      ocupado_q <= ocupado_d;
      fin_q     <= fin_d;
    end
  end

  assign Selec_Mux_DD = sel_q;
  assign ocupado      = ocupado_q;
  assign fin          = fin_q;
  assign fase_actual  = estado_q;

endmodule

// File: tb/tb_secuenciador_bloques_datos.sv
// -----------------------------------------------------------------------------
// tb_secuenciador_bloques_datos
//
// Self-checking bench for secuenciador_bloques_datos with T_FASE = 4. The
// reference model describes a sequence as a schedule: on start it lists every
// cycle the sequence will occupy (INICIO, each enabled data phase, FIN) and
// then consumes that list one entry per clock; an abort replaces the rest of
// the list with a single FIN entry and reset discards it.
// -----------------------------------------------------------------------------
module tb_secuenciador_bloques_datos;

  localparam int T = 4;

  logic       clk;
  logic       reset;
  logic       inicio;
  logic       cancelar;
  logic [2:0] sel_bloques;
  logic [3:0] Selec_Mux_DD;
  logic       ocupado;
  logic       fin;
  logic [2:0] fase_actual;

  int checks   = 0;
  int failures = 0;

  secuenciador_bloques_datos #(
    .T_FASE     (T),
    .ANCHO_CONT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inicio       (inicio),
    .cancelar     (cancelar),
    .sel_bloques  (sel_bloques),
    .Selec_Mux_DD (Selec_Mux_DD),
    .ocupado      (ocupado),
    .fin          (fin),
    .fase_actual  (fase_actual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: one entry per clock cycle of expected visible behaviour.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] code;
    logic       busy;
    logic       done;
    logic [2:0] fase;
  } paso_t;

  localparam paso_t PASO_REPOSO = '{code: 4'h0, busy: 1'b0, done: 1'b0, fase: 3'd0};
  localparam paso_t PASO_FIN    = '{code: 4'h0, busy: 1'b0, done: 1'b1, fase: 3'd5};

  paso_t actual = PASO_REPOSO;
  paso_t plan[$];

  function automatic paso_t paso_fase(input int f);
    paso_t p;
    p.code = 4'(f);
    p.busy = 1'b1;
    p.done = 1'b0;
    p.fase = 3'(f);
    return p;
  endfunction

  task automatic arrancar(input logic [2:0] mascara);
    plan.delete();
    for (int c = 0; c < T; c++) plan.push_back(paso_fase(1));
    for (int b = 0; b < 3; b++)
      if (mascara[b])
        for (int c = 0; c < T; c++) plan.push_back(paso_fase(b + 2));
    plan.push_back(PASO_FIN);
    actual = plan.pop_front();
  endtask

  task automatic modelo(input logic r, input logic ini, input logic can,
                        input logic [2:0] sel);
    if (r) begin
      plan.delete();
      actual = PASO_REPOSO;
    end else if (actual.fase == 3'd0) begin
      if (ini) arrancar(sel);
    end else if (actual.done) begin
      actual = PASO_REPOSO;
    end else if (can) begin
      plan.delete();
      actual = PASO_FIN;
    end else begin
      actual = plan.pop_front();
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: sample the inputs that are stable across the edge, advance the
  // model, then compare every output 1 time unit after the edge.
  task automatic tick();
    logic       r, ini, can;
    logic [2:0] sel;
    @(posedge clk);
    r   = reset;
    ini = inicio;
    can = cancelar;
    sel = sel_bloques;
    #1;
    modelo(r, ini, can, sel);
    check("codigo",  8'(Selec_Mux_DD), 8'(actual.code));
    check("ocupado", 8'(ocupado),      8'(actual.busy));
    check("fin",     8'(fin),          8'(actual.done));
    check("fase",    8'(fase_actual),  8'(actual.fase));
  endtask

  task automatic pulso_inicio(input logic [2:0] mascara);
    sel_bloques = mascara;
    inicio      = 1'b1;
    tick();
    inicio      = 1'b0;
  endtask

  int n_fin;
  int n_ocupado;
  int n_datos;
  int n_largo;

  initial begin
    reset       = 1'b1;
    inicio      = 1'b0;
    cancelar    = 1'b0;
    sel_bloques = 3'b000;

    // Reset state.
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Full sweep: fin exactly once, busy for 4 phases of T cycles.
    pulso_inicio(3'b111);
    n_fin = 0;
    n_ocupado = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fin) n_fin++;
      if (ocupado) n_ocupado++;
    end
    check("barrido_fin_pulsos", 8'(n_fin), 8'd1);
    check("barrido_ciclos_ocupado", 8'(n_ocupado + 1), 8'(4 * T));

    // Masked sweep: INICIO then HORA only.
    pulso_inicio(3'b100);
    for (int i = 0; i < 12; i++) tick();

    // Empty mask: no data-phase code ever appears.
    pulso_inicio(3'b000);
    n_datos = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Selec_Mux_DD >= 4'h2) n_datos++;
    end
    check("vacio_sin_fases_datos", 8'(n_datos), 8'd0);

    // Abort on the 2nd cycle of FECHA, then inicio during FIN is ignored.
    pulso_inicio(3'b111);                       // now cycle 1
    for (int i = 0; i < 9; i++) tick();         // now cycle 10 (2nd of FECHA)
    check("abort_en_fecha", 8'(fase_actual), 8'd3);
    cancelar = 1'b1;
    tick();                                     // FIN
    check("abort_fin", 8'(fin), 8'd1);
    inicio = 1'b1;
    tick();                                     // back to REPOSO, start ignored
    inicio   = 1'b0;
    cancelar = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Reset during MS, then a clean restart.
    pulso_inicio(3'b111);
    for (int i = 0; i < 5; i++) tick();         // in MS
    reset = 1'b1;
    tick();
    check("reset_sin_fin", 8'(fin), 8'd0);
    reset = 1'b0;
    pulso_inicio(3'b011);
    for (int i = 0; i < 16; i++) tick();

    // Ignored inputs: mask change during MS, inicio pulses during HORA.
    pulso_inicio(3'b111);
    n_largo = 1;
    for (int i = 0; i < 20; i++) begin
      sel_bloques = (i >= 4 && i < 8) ? 3'b000 : 3'b111;
      inicio      = (i == 13 || i == 15);
      tick();
      if (ocupado) n_largo++;
    end
    inicio = 1'b0;
    check("ignorados_duracion", 8'(n_largo), 8'(4 * T));

    // Randomised sequences with occasional aborts, stray starts and resets.
    for (int s = 0; s < 25; s++) begin
      pulso_inicio(3'($urandom_range(0, 7)));
      for (int i = 0; i < int'($urandom_range(4, 22)); i++) begin
        cancelar    = ($urandom_range(0, 15) == 0);
        inicio      = ($urandom_range(0, 7) == 0);
        reset       = ($urandom_range(0, 63) == 0);
        sel_bloques = 3'($urandom_range(0, 7));
        tick();
      end
      cancelar = 1'b0;
      inicio   = 1'b0;
      reset    = 1'b0;
      for (int i = 0; i < 2; i++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
